// File: rtl/sinus_sample_streamer_if.sv
// Sample stream from the sinusoid table player to the DAC path (valid/ready).
interface sinus_sample_streamer_if #(
  parameter int SAMPLE_W = 12
);
  logic [SAMPLE_W-1:0] sample;
  logic [3:0]          sample_flags;
  logic [5:0]          sample_index;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample, sample_flags, sample_index, sample_valid, input sample_ready);
  modport slave  (input sample, sample_flags, sample_index, sample_valid, output sample_ready);
endinterface

// File: rtl/sinus_sample_streamer.sv
// Snapshots the packed 64-word sinusoid table on start and streams samples with step/rate control.
// Optional: define SINUS_SIGNED_OUT_EN to emit two's-complement samples instead of offset binary.
module sinus_sample_streamer #(
  parameter int BITS_DATA_OUT = 1024,
  parameter int BITS_DATA     = 16,
  parameter int SAMPLES       = 64,
  parameter int SAMPLE_W      = 12,
  parameter int DIV_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS_DATA_OUT-1:0] table_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [5:0]               step,
  input  logic [DIV_W-1:0]         rate_div,
  output logic                     busy,
  output logic                     done,
  sinus_sample_streamer_if.master  smp
);
  localparam int IDX_W = 6;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} state_t;

  typedef struct packed {
    logic [3:0]          flags;
    logic [SAMPLE_W-1:0] sample;
  } word_t;

  typedef struct packed {
    logic [IDX_W-1:0]    index;
    logic [3:0]          flags;
    logic [SAMPLE_W-1:0] sample;
  } out_t;

  state_t                             state;
  logic [SAMPLES-1:0][BITS_DATA-1:0]  snap;
  logic [IDX_W-1:0]                   idx, nidx, step_q;
  logic                               wrap, loop_q, stop_q, vld;
  logic [DIV_W-1:0]                   rd_q, cnt;
  word_t                              w_cur, w_nxt;
  out_t                               out_q;

  // wrap is the carry out of the 6-bit index add: one period has been covered
  assign {wrap, nidx} = {1'b0, idx} + {1'b0, step_q};

  // word 0 sits at the MSB end of the table, i.e. the highest packed element
  assign w_cur = snap[IDX_W'(SAMPLES-1) - idx];
  assign w_nxt = snap[IDX_W'(SAMPLES-1) - nidx];

  function automatic out_t mk(input word_t w, input logic [IDX_W-1:0] i);
    out_t o;
    o.index = i;
    o.flags = w.flags;
`ifdef SINUS_SIGNED_OUT_EN
    o.sample = {~w.sample[SAMPLE_W-1], w.sample[SAMPLE_W-2:0]};
`else
    o.sample = w.sample;
`endif
    return o;
  endfunction

  assign smp.sample       = out_q.sample;
  assign smp.sample_flags = out_q.flags;
  assign smp.sample_index = out_q.index;
  assign smp.sample_valid = vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      snap   <= '0;
      idx    <= '0;
      step_q <= '0;
      loop_q <= 1'b0;
      stop_q <= 1'b0;
      rd_q   <= '0;
      cnt    <= '0;
      out_q  <= '0;
      vld    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !stop) begin
          snap   <= table_data;
          idx    <= '0;
          step_q <= (step == '0) ? IDX_W'(1) : step;
          loop_q <= loop_en;
          rd_q   <= rate_div;
          stop_q <= 1'b0;
          busy   <= 1'b1;
          state  <= LOAD;
        end
        LOAD: if (stop) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          out_q <= mk(w_cur, idx);
          vld   <= 1'b1;
          state <= SEND;
        end
        SEND: if (vld && smp.sample_ready) begin
          // a pending stop outranks the one-shot wrap, so a stopped run never signals done
          if (stop_q || stop) begin
            vld   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wrap && !loop_q) begin
            vld   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (rd_q == '0) begin
            idx   <= nidx;
            out_q <= mk(w_nxt, nidx);
          end else begin
            vld   <= 1'b0;
            idx   <= nidx;
            cnt   <= rd_q - 1'b1;
            state <= GAP;
          end
        end else begin
          stop_q <= stop_q | stop;
        end
        GAP: if (stop) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else if (cnt == '0) begin
          out_q <= mk(w_cur, idx);
          vld   <= 1'b1;
          state <= SEND;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          vld   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sinus_sample_streamer.sv
// Randomized bench for sinus_sample_streamer against a sequence-level reference model.
module tb_sinus_sample_streamer;
  logic         clk = 1'b0;
  logic         rst;
  logic [1023:0] table_data;
  logic         start, stop, loop_en;
  logic [5:0]   step;
  logic [15:0]  rate_div;
  logic         busy, done;
  logic [15:0]  tbl [64];
  int           n_chk = 0;
  int           n_err = 0;

  sinus_sample_streamer_if #(.SAMPLE_W(12)) smp ();

  sinus_sample_streamer dut (
    .clk(clk), .rst(rst), .table_data(table_data), .start(start), .stop(stop),
    .loop_en(loop_en), .step(step), .rate_div(rate_div), .busy(busy), .done(done),
    .smp(smp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_s(input logic [11:0] raw);
`ifdef SINUS_SIGNED_OUT_EN
    return raw ^ 12'h800;
`else
    return raw;
`endif
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    logic [15:0] w;
    w = tbl[i];
    return {10'd0, 6'(i), w[15:12], exp_s(w[11:0])};
  endfunction

  function automatic logic [31:0] got_word();
    return {10'd0, smp.sample_index, smp.sample_flags, smp.sample};
  endfunction

  task automatic pack_table();
    for (int i = 0; i < 64; i++) table_data[1023-16*i -: 16] = tbl[i];
  endtask

  // rmode 0: ready held high, 1: random ready plus stray starts, 2: 10-cycle stall at bp_idx
  task automatic play(input int stp, input bit lp, input int rd, input int rmode,
                      input int nmax, input int bp_idx);
    int   q[$];
    int   s, cyc, first_v, last_x, xfers, dones, bp_left;
    bit   bp_used, prev_stall, rdy, to;
    logic [31:0] prev_o;
    s = (stp % 64 == 0) ? 1 : stp % 64;
    if (lp) for (int k = 0; k < nmax; k++) q.push_back((k * s) % 64);
    else    for (int i = 0; i < 64; i += s) q.push_back(i);
    cyc = 0; first_v = -1; last_x = -1; xfers = 0; dones = 0; bp_left = 0;
    bp_used = 0; prev_stall = 0; prev_o = '0;
    pack_table();
    step = 6'(stp); loop_en = lp; rate_div = 16'(rd); start = 1'b1;
    smp.sample_ready = 1'b0;
    tick(); cyc = 1; start = 1'b0;
    table_data = {32{$urandom()}};
    while (cyc < 30000) begin
      if (done) dones++;
      if (!lp && q.size() == 0 && !busy) break;
      if (smp.sample_valid && first_v < 0) first_v = cyc;
      if (prev_stall) chk("hold", {smp.sample_valid, got_word()[30:0]}, {1'b1, prev_o[30:0]});
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (smp.sample_valid && int'(smp.sample_index) == bp_idx && !bp_used) begin
            bp_used = 1'b1;
            bp_left = 10;
            chk("bp_sample", {20'd0, smp.sample}, {20'd0, exp_s(tbl[bp_idx][11:0])});
          end
          rdy = (bp_left == 0);
          if (bp_left > 0) bp_left--;
        end
      endcase
      smp.sample_ready = rdy;
      if (smp.sample_valid && rdy) begin
        if (q.size() == 0) chk("extra_xfer", got_word(), 32'hFFFF_FFFF);
        else chk("xfer", got_word(), exp_word(q.pop_front()));
        if (rmode == 0 && last_x >= 0) chk("spacing", cyc - last_x, rd + 1);
        last_x = cyc;
        xfers++;
      end
      start = (rmode == 1 && q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_stall = smp.sample_valid && !rdy;
      prev_o = got_word();
      if (lp && xfers == nmax) break;
      tick(); cyc++;
    end
    start = 1'b0;
    to = (cyc >= 30000);
    chk("timeout", {31'd0, to}, 0);
    chk("latency", first_v, 2);
    chk("q_left", q.size(), 0);
    chk("done_cnt", dones, lp ? 0 : 1);
    if (bp_idx >= 0) chk("bp_seen", {31'd0, bp_used}, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; step = '0; rate_div = '0;
    smp.sample_ready = 1'b0; table_data = '0;
    for (int i = 0; i < 64; i++) tbl[i] = {1'b0, 3'($urandom()), 12'($urandom())};
    tbl[0] = 16'h8801;
    tbl[5][11:0]  = 12'hBD4;
    tbl[16][11:0] = 12'hFFF;
    tbl[32][11:0] = 12'h79A;
    tbl[47][11:0] = 12'h001;
    tbl[48][11:0] = 12'h005;
    repeat (3) tick();
    chk("rst_out", {got_word()[21:0], smp.sample_valid, busy, done}, 0);
    rst = 1'b0;
    tick();
    chk("idle_out", {got_word()[21:0], smp.sample_valid, busy, done}, 0);

    play(1, 0, 0, 0, 0, -1);
    play(16, 0, 3, 0, 0, -1);
    play(1, 0, 0, 2, 0, 5);
    for (int r = 0; r < 4; r++)
      play(int'($urandom_range(0, 63)), 0, int'($urandom_range(0, 3)), 1, 0, -1);

    // continuous run, then stop while sitting in the inter-sample gap
    play(1, 1, 2, 0, 130, -1);
    tick();
    chk("gap_state", {smp.sample_valid, busy}, {1'b0, 1'b1});
    stop = 1'b1; smp.sample_ready = 1'b0;
    tick();
    stop = 1'b0;
    chk("gap_stop", {smp.sample_valid, busy, done}, 0);

    // stop while a sample waits for ready: the held sample still goes out once
    pack_table();
    step = 6'd1; loop_en = 1'b0; rate_div = '0; smp.sample_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("ss_valid", {smp.sample_valid, got_word()[21:0]}, {1'b1, exp_word(0)[21:0]});
    stop = 1'b1;
    tick(); stop = 1'b0;
    chk("ss_hold1", {smp.sample_valid, busy}, 2'b11);
    tick();
    chk("ss_hold2", {smp.sample_valid, got_word()[21:0]}, {1'b1, exp_word(0)[21:0]});
    smp.sample_ready = 1'b1;
    tick(); smp.sample_ready = 1'b0;
    chk("ss_idle", {smp.sample_valid, busy, done}, 0);

    // asynchronous reset mid-stream
    step = 6'd3; rate_div = '0; smp.sample_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (10) tick();
    chk("pre_rst", {smp.sample_valid, busy}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("rst_async", {got_word()[21:0], smp.sample_valid, busy, done}, 0);
    smp.sample_ready = 1'b0;
    start = 1'b1;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    repeat (4) tick();
    chk("rst_start", {smp.sample_valid, busy, done}, 0);
    play(5, 0, 1, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sinus_sample_streamer.md
Name: sinus_sample_streamer

Overview:
- Consumer of the packed 64-entry sinusoid table: 1024-bit vector of 16-bit words, 4-bit flags + 12-bit offset-binary sample.
- Snapshots the table on start and streams one sample per transfer to the DAC path over a valid/ready handshake.
- Programmable phase step and inter-sample rate divider.
- One-shot (single period) or continuous loop.

Parameters:
- BITS_DATA_OUT, 1024, width of packed table input
- BITS_DATA, 16, width of one table word
- SAMPLES, 64, number of words (BITS_DATA_OUT/BITS_DATA)
- SAMPLE_W, 12, sample field width (word bits [11:0])
- DIV_W, 16, rate divider width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- table_data  in  BITS_DATA_OUT  packed table; word i at bits [BITS_DATA_OUT-1-16*i -: 16], word 0 at MSB
- start  in  1  begin playback (level sampled, honoured only in IDLE)
- stop  in  1  abort playback
- loop_en  in  1  1 = continuous, 0 = one period
- step  in  6  index increment per sample; 0 treated as 1
- rate_div  in  DIV_W  extra idle cycles between transfers
- sample_ready  in  1  downstream accepts sample
- sample  out  SAMPLE_W  current sample
- sample_flags  out  4  word bits [15:12]; bit 3 = period-start marker
- sample_index  out  6  table index of current sample
- sample_valid  out  1  sample/flags/index valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on one-shot completion

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset value of all outputs is 0. Internal index, counter, snapshot and state are cleared. Reset mid-operation takes effect immediately, with no completion of the pending transfer.
- States: IDLE, LOAD, SEND, GAP, DONE.
- IDLE, start=1 at edge E0:
  - snapshot <= table_data, idx <= 0, latch step/loop_en/rate_div, go LOAD.
  - Later table_data changes have no effect until the next start.
- LOAD at edge E1: register sample/flags/index from snapshot[idx], sample_valid <= 1, go SEND. Start-to-valid latency is 2 edges.
- SEND:
  - Outputs are held stable while sample_valid=1 and sample_ready=0. valid never drops without a transfer.
  - Transfer edge = sample_valid & sample_ready.
  - nidx = (idx + step) mod 64; wrap = carry out of that add.
- At the transfer edge:
  - wrap=1 and loop=0: valid <= 0, go DONE.
  - stop pending: valid <= 0, go IDLE.
  - rate_div=0: load snapshot[nidx] directly, valid stays 1 (back-to-back).
  - Otherwise: valid <= 0, cnt <= rate_div-1, idx <= nidx, go GAP.
- GAP: cnt decrements each cycle. At cnt=0, load snapshot[idx], valid <= 1, go SEND.
- With sample_ready held high, transfer spacing is exactly rate_div+1 cycles.
- DONE: done=1 for one cycle, then IDLE.
- stop:
  - In LOAD or GAP: go IDLE at the next edge, valid stays 0, no done.
  - In SEND: a stop flag is latched. The pending transfer completes, then IDLE.
  - stop has priority over wrap, so a stopped run never pulses done.
- start while busy is ignored. start and stop together in IDLE: stop wins, remain IDLE.
- One-shot length is ceil(64/step) samples.
- Loop mode wraps idx mod 64 with no gap beyond rate_div. Changing loop_en mid-run has no effect (latched).

Optional Feature:
- Macro: SINUS_SIGNED_OUT_EN.
- Defined: sample is two's complement, i.e. MSB of word bits [11:0] inverted (0x800 -> 0x000, 0xFFF -> 0x7FF, 0x001 -> 0x801).
- Undefined: sample is raw offset binary.
- Flags and index are unaffected either way.

Test Plan:
- Standard table, step=1, loop_en=0, rate_div=0, ready=1, start pulse:
  - valid 2 edges after start.
  - 64 consecutive transfers, no bubbles.
  - First sample 0x801 flags 0x8; index 16 = 0xFFF; index 47 = 0x001.
  - done pulses once, busy falls.
- step=16, loop_en=0, rate_div=3:
  - Samples at indices 0,16,32,48 only (0x801, 0xFFF, 0x79A, 0x005), spaced 4 cycles.
  - done after the 4th transfer.
- Backpressure: ready low for 10 cycles at index 5 -> sample 0xBD4 held stable with valid high, idx not advanced; resumes index 6 after ready returns.
- loop_en=1, step=1, run 130 transfers, then stop during GAP:
  - Index sequence wraps 63 -> 0 (flags 0x8 reappears).
  - Returns IDLE next edge, no done.
- stop asserted in SEND with ready=0 -> valid stays high; one transfer on ready, then IDLE.
- rst asserted mid-stream -> all outputs 0 asynchronously.
- start in same cycle as rst release -> no playback until a new start is sampled.
- SINUS_SIGNED_OUT_EN defined, step=1 -> index 0 gives 0x001, index 16 gives 0x7FF, index 47 gives 0x801.
